mem_responder: RTL and testbench

- Memory-side responder for the core's memory access unit.
- Accepts a single sized load/store request (byte, half-word or word) and returns busy, read data and an access-fault indication.
- Replaces the software memory model behind the access unit with synthesizable RTL: a byte-lane word array, a programmable wait-state counter and address/size checking.
- Sits between the memory access unit and on-chip RAM.

---
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: byte-lane word array behind a sized load/store port,
// with programmable wait states and address/size checking.
//
// state  | meaning
// IDLE   | waiting for req; rejected requests set fault without leaving IDLE
// ACCESS | wait-state countdown; access performed when the counter reaches 0
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_write,
  input  logic        is_unsigned,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        fault
);

  localparam int unsigned WORDS     = 2 ** (ADDR_BITS - 2);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   lat_write;
  logic                   lat_unsigned;
  logic [1:0]             lat_op;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [31:0]            lat_wdata;

  logic [31:0]            mem [WORDS];

  logic                   misaligned;
  logic                   out_of_range;
  logic                   bad;
  logic                   done;
  logic [31:0]            word_rd;
  logic [31:0]            shifted;
  logic [31:0]            load_val;
  logic [3:0]             lane_en;
  logic [31:0]            wr_word;

  always_comb begin
    misaligned   = (op[1] & (addr[1] | addr[0])) | (op[0] & addr[0]);
    out_of_range = addr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS];
    bad          = (op == 2'b11) | misaligned | out_of_range;
    done         = (state == ACCESS) && (cnt == 4'd0);
  end

  // Load path: shift the addressed lane(s) down, then extend.
  always_comb begin
    word_rd  = mem[lat_addr[ADDR_BITS-1:2]];
    shifted  = word_rd >> {lat_addr[1:0], 3'b000};
    load_val = '0;
    case (lat_op)
      2'b00:   load_val = {{24{~lat_unsigned & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~lat_unsigned & shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = word_rd;
      default: load_val = '0;
    endcase
  end

  // Store path: replicate the right-aligned data across lanes, enable only the addressed ones.
  always_comb begin
    lane_en = 4'b0000;
    wr_word = lat_wdata;
    case (lat_op)
      2'b00: begin
        lane_en = 4'b0001 << lat_addr[1:0];
        wr_word = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        lane_en = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{lat_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Array is not reset; an async reset drops state to IDLE so an aborted store never commits.
  always_ff @(posedge clk) begin
    if (done && lat_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[lat_addr[ADDR_BITS-1:2]][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      fault        <= 1'b0;
      rdata        <= '0;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_op       <= 2'b00;
      lat_addr     <= '0;
      lat_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (bad) begin
              fault <= 1'b1;
            end else begin
              lat_write    <= is_write;
              lat_unsigned <= is_unsigned;
              lat_op       <= op;
              lat_addr     <= addr[ADDR_BITS-1:0];
              lat_wdata    <= wdata;
              fault        <= 1'b0;
              busy         <= 1'b1;
              cnt          <= WAIT_INIT;
              state        <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!lat_write) rdata <= load_val;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: dut1 runs with one wait state, dut3 with three.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, req1, w1, u1, busy1, fault1;
  logic [1:0]  op1;
  logic [31:0] addr1, wd1, rdata1;
  logic        reset3, req3, w3, u3, busy3, fault3;
  logic [1:0]  op3;
  logic [31:0] addr3, wd3, rdata3;

  mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .req(req1), .is_write(w1), .is_unsigned(u1), .op(op1),
    .addr(addr1), .wdata(wd1), .rdata(rdata1), .busy(busy1), .fault(fault1));

  mem_responder #(.ADDR_BITS(12), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .is_write(w3), .is_unsigned(u3), .op(op3),
    .addr(addr3), .wdata(wd3), .rdata(rdata3), .busy(busy3), .fault(fault3));

  typedef struct {
    bit          f;
    logic [31:0] rd;
    int          len;   // expected busy cycles; <= 0 means not checked
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors: a response is either a rejected request (fault, busy low
  // right after sampling) or busy falling.
  bit   samp1, pb1, samp3, pb3;
  int   bl1, bl3;
  exp_t e1, e3;

  always @(posedge clk) samp1 <= reset1 & req1 & ~busy1;
  always @(posedge clk) samp3 <= reset3 & req3 & ~busy3;

  initial begin
    pb1 = 1'b0; bl1 = 0;
    forever begin
      @(negedge clk);
      if (busy1) bl1++;
      if ((samp1 && !busy1) || (pb1 && !busy1)) begin
        if (q1.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL dut1 unexpected response: rdata %h fault %b, none expected", rdata1, fault1);
        end else begin
          e1 = q1.pop_front();
          check("dut1 fault", 32'(fault1), 32'(e1.f));
          check("dut1 rdata", rdata1, e1.rd);
          if (e1.len > 0) check("dut1 busy_len", bl1, e1.len);
        end
      end
      if (!busy1) bl1 = 0;
      pb1 = busy1;
    end
  end

  initial begin
    pb3 = 1'b0; bl3 = 0;
    forever begin
      @(negedge clk);
      if (busy3) bl3++;
      if ((samp3 && !busy3) || (pb3 && !busy3)) begin
        if (q3.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL dut3 unexpected response: rdata %h fault %b, none expected", rdata3, fault3);
        end else begin
          e3 = q3.pop_front();
          check("dut3 fault", 32'(fault3), 32'(e3.f));
          check("dut3 rdata", rdata3, e3.rd);
          if (e3.len > 0) check("dut3 busy_len", bl3, e3.len);
        end
      end
      if (!busy3) bl3 = 0;
      pb3 = busy3;
    end
  end

  task automatic wait_drain(input int sel);
    for (int i = 0; i < 40; i++) begin
      if ((sel == 1 ? q1.size() : q3.size()) == 0) return;
      @(negedge clk); #1;
    end
    vectors++; miscompares++;
    $display("FAIL dut%0d timeout: %0d responses outstanding, 0 required", sel,
             (sel == 1 ? q1.size() : q3.size()));
    if (sel == 1) q1.delete(); else q3.delete();
  endtask

  task automatic drive(input int sel, input bit w, input bit u, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] wd, input bit ef,
                       input logic [31:0] er, input int len);
    exp_t e;
    e.f = ef; e.rd = er; e.len = len;
    @(negedge clk);
    if (sel == 1) begin
      q1.push_back(e); w1 = w; u1 = u; op1 = o; addr1 = a; wd1 = wd; req1 = 1'b1;
    end else begin
      q3.push_back(e); w3 = w; u3 = u; op3 = o; addr3 = a; wd3 = wd; req3 = 1'b1;
    end
    @(posedge clk); #1;
    if (sel == 1) begin
      req1 = 1'b0; w1 = 1'($urandom); u1 = 1'($urandom); op1 = 2'($urandom);
      addr1 = $urandom; wd1 = $urandom;
    end else begin
      req3 = 1'b0; w3 = 1'($urandom); u3 = 1'($urandom); op3 = 2'($urandom);
      addr3 = $urandom; wd3 = $urandom;
    end
  endtask

  task automatic issue(input int sel, input bit w, input bit u, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] wd, input bit ef,
                       input logic [31:0] er, input int len);
    drive(sel, w, u, o, a, wd, ef, er, len);
    wait_drain(sel);
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  initial begin
    reset1 = 1'b0; req1 = 1'b0; w1 = 1'b0; u1 = 1'b0; op1 = 2'b00; addr1 = '0; wd1 = '0;
    reset3 = 1'b0; req3 = 1'b0; w3 = 1'b0; u3 = 1'b0; op3 = 2'b00; addr3 = '0; wd3 = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst fault", 32'(fault1), 32'd0);
    check("rst rdata", rdata1, 32'd0);
    reset1 = 1'b1; reset3 = 1'b1;

    // dut1, one wait state: (sel, write, unsigned, op, addr, wdata, exp fault, exp rdata, busy len)
    issue(1, 1, 0, W, 32'h00, 32'h0102_0304, 0, 32'h0000_0000, 2);
    issue(1, 1, 0, W, 32'h10, 32'hDEAD_BEEF, 0, 32'h0000_0000, 2);
    issue(1, 0, 0, W, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 2);
    issue(1, 1, 0, W, 32'h20, 32'h1122_3344, 0, 32'hDEAD_BEEF, 2);
    issue(1, 1, 0, B, 32'h21, 32'hAAAA_AA80, 0, 32'hDEAD_BEEF, 2);
    issue(1, 0, 0, B, 32'h21, 32'h0,         0, 32'hFFFF_FF80, 2);
    issue(1, 0, 1, B, 32'h21, 32'h0,         0, 32'h0000_0080, 2);
    issue(1, 0, 0, W, 32'h20, 32'h0,         0, 32'h1122_8044, 2);
    issue(1, 0, 0, B, 32'h22, 32'h0,         0, 32'h0000_0022, 2);
    issue(1, 0, 0, H, 32'h20, 32'h0,         0, 32'hFFFF_8044, 2);
    issue(1, 1, 0, W, 32'h30, 32'h0,         0, 32'hFFFF_8044, 2);
    issue(1, 1, 0, H, 32'h32, 32'h5555_8001, 0, 32'hFFFF_8044, 2);
    issue(1, 0, 0, H, 32'h32, 32'h0,         0, 32'hFFFF_8001, 2);
    issue(1, 0, 1, H, 32'h32, 32'h0,         0, 32'h0000_8001, 2);
    issue(1, 0, 0, W, 32'h30, 32'h0,         0, 32'h8001_0000, 2);
    // rejected requests: array and rdata must stay as they are
    issue(1, 1, 0, H, 32'h33,   32'h0000_FFFF, 1, 32'h8001_0000, 0);
    issue(1, 1, 0, W, 32'h12,   32'h0,         1, 32'h8001_0000, 0);
    issue(1, 1, 0, X, 32'h20,   32'h0,         1, 32'h8001_0000, 0);
    issue(1, 1, 0, W, 32'h1000, 32'hFFFF_FFFF, 1, 32'h8001_0000, 0);
    issue(1, 0, 0, W, 32'h1000, 32'h0,         1, 32'h8001_0000, 0);
    check("fault held", 32'(fault1), 32'd1);
    issue(1, 0, 0, W, 32'h30, 32'h0,         0, 32'h8001_0000, 2);
    issue(1, 0, 0, W, 32'h10, 32'h0,         0, 32'hDEAD_BEEF, 2);
    issue(1, 0, 0, W, 32'h20, 32'h0,         0, 32'h1122_8044, 2);
    issue(1, 0, 0, W, 32'h00, 32'h0,         0, 32'h0102_0304, 2);

    // dut3, three wait states
    issue(3, 1, 0, W, 32'h40, 32'hCAFE_F00D, 0, 32'h0000_0000, 4);
    drive(3, 0, 0, W, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 4);
    @(negedge clk); req3 = 1'b1; op3 = X; addr3 = 32'h44; w3 = 1'b1;
    @(negedge clk); op3 = W; addr3 = 32'h48; w3 = 1'b0;
    @(negedge clk); req3 = 1'b0;
    wait_drain(3);
    repeat (4) @(negedge clk);
    check("dut3 ignored req fault", 32'(fault3), 32'd0);
    check("dut3 ignored req rdata", rdata3, 32'hCAFE_F00D);

    // reset in the middle of a store's countdown
    drive(3, 1, 0, W, 32'h40, 32'h1234_5678, 0, 32'h0000_0000, 0);
    @(posedge clk); #1;
    reset3 = 1'b0;
    #1;
    check("abort busy", 32'(busy3), 32'd0);
    check("abort fault", 32'(fault3), 32'd0);
    check("abort rdata", rdata3, 32'd0);
    wait_drain(3);
    @(negedge clk); reset3 = 1'b1;
    issue(3, 0, 0, W, 32'h40, 32'h0, 0, 32'hCAFE_F00D, 4);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
